imem_responder: RTL and testbench



---
 rtl/imem_responder.sv | 135 +++++++++++++
 tb/tb_imem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: responder end of the instruction-fetch interface.
// It accepts one word-read request at a time and models a fixed multi-cycle
// memory latency. It returns one 16-bit word per request over a valid/ready
// handshake. A flush aborts the in-flight read, and a side port preloads the
// program store.
module imem_responder #(
    parameter int LATENCY    = 2,   // legal range 1..15
    parameter int DEPTH_LOG2 = 10   // 2^DEPTH_LOG2 words of 16 bits
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    output logic        resp_err,
    input  logic        flush,
    input  logic        load_en,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data
);

    localparam int unsigned WORDS    = 1 << DEPTH_LOG2;
    localparam logic [15:0] WORDS16  = 16'(WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic [15:0] addr_q;
    logic [15:0] addr_d;

    logic [15:0] mem [WORDS];

    logic                  accept;
    logic                  enter_resp;
    logic                  rd_err;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  ld_oor;
    logic [DEPTH_LOG2-1:0] ld_idx;
    logic                  unused_load_lsb;

    // A word port ignores bit 0 of the preload address.
    assign unused_load_lsb = load_addr[0];

    assign req_ready  = (state_q == IDLE) && !flush;
    assign resp_valid = (state_q == RESP);
    assign accept     = req_valid && req_ready;

    // The read address is the one being latched this edge. This lets LATENCY==1
    // sample the array on the same edge that accepts the request.
    assign rd_idx = addr_d[DEPTH_LOG2:1];
    assign rd_err = addr_d[0] | ({1'b0, addr_d[15:1]} >= WORDS16);

    assign ld_idx = load_addr[DEPTH_LOG2:1];
    assign ld_oor = ({1'b0, load_addr[15:1]} >= WORDS16);

    // Next-state and counter logic for the IDLE/BUSY/RESP handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 4'd1) begin
                    // The exit is decided on the decremented count. This puts
                    // resp_valid exactly LATENCY cycles after the acceptance edge.
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // A flush and a consume in the same cycle both end in IDLE.
                // The response is retired only once.
                if (flush || resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    // State, counter and address registers. The response is captured on RESP entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (enter_resp) begin
                resp_err  <= rd_err;
                resp_data <= rd_err ? '0 : mem[rd_idx];
            end
        end
    end

    // Preload writes. Reset does not touch the array, and out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (load_en && !ld_oor) begin
            mem[ld_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed, table-driven bench for imem_responder. The main table runs a
// LATENCY=2 instance. Short hand-written sequences cover LATENCY=4 flush timing
// and LATENCY=1 turnaround. All three instances share the same input stimulus.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [15:0] req_addr = '0;
    logic        resp_ready = 1'b0;
    logic        flush = 1'b0;
    logic        load_en = 1'b0;
    logic [15:0] load_addr = '0;
    logic [15:0] load_data = '0;

    logic        rdy2, vld2, err2;
    logic [15:0] dat2;
    logic        rdy4, vld4, err4;
    logic [15:0] dat4;
    logic        rdy1, vld1, err1;
    logic [15:0] dat1;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    always #5 clk = ~clk;

    imem_responder #(.LATENCY(2), .DEPTH_LOG2(10)) u_lat2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy2), .resp_valid(vld2), .resp_ready(resp_ready),
        .resp_data(dat2), .resp_err(err2), .flush(flush), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data)
    );

    imem_responder #(.LATENCY(4), .DEPTH_LOG2(10)) u_lat4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy4), .resp_valid(vld4), .resp_ready(resp_ready),
        .resp_data(dat4), .resp_err(err4), .flush(flush), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data)
    );

    imem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) u_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy1), .resp_valid(vld1), .resp_ready(resp_ready),
        .resp_data(dat1), .resp_err(err1), .flush(flush), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data)
    );

    typedef struct {
        logic        rst;
        logic        rv;
        logic [15:0] ra;
        logic        rr;
        logic        fl;
        logic        le;
        logic [15:0] la;
        logic [15:0] ld;
        logic        e_rdy;
        logic        e_vld;
        logic        chk;     // compare resp_data/resp_err on this row
        logic [15:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic row(input logic r, input logic rv, input logic [15:0] ra,
                       input logic rr, input logic fl, input logic le,
                       input logic [15:0] la, input logic [15:0] ld,
                       input logic e_rdy, input logic e_vld, input logic chk,
                       input logic [15:0] e_data, input logic e_err);
        vec_t v;
        v.rst = r; v.rv = rv; v.ra = ra; v.rr = rr; v.fl = fl;
        v.le = le; v.la = la; v.ld = ld;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.chk = chk;
        v.e_data = e_data; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic rv, input logic [15:0] ra,
                         input logic rr, input logic fl);
        rst = r; req_valid = rv; req_addr = ra; resp_ready = rr; flush = fl;
        load_en = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat_seen;
        logic saw_vld;

        // rst  rv ra       rr fl le la       ld       rdy vld chk data     err
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0000, 0); // reset state
        row(0, 0, 16'h0000, 0, 0, 1, 16'h0010, 16'hA5C3, 1, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 0, 0, 1, 16'h0020, 16'h1234, 1, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0BEE, 1, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 0, 0, 1, 16'h0800, 16'hDEAD, 1, 0, 0, 16'h0000, 0); // dropped
        row(0, 0, 16'h0000, 0, 0, 1, 16'h07FF, 16'h7E57, 1, 0, 0, 16'h0000, 0); // last word, lsb ignored
        row(0, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0); // accept, cycle 0
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0); // cycle 1
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'hA5C3, 0); // cycle 2
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'hA5C3, 0); // backpressure
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'hA5C3, 0);
        row(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'hA5C3, 0); // consume
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0);
        row(0, 1, 16'h0011, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0); // misaligned
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0000, 1);
        row(0, 1, 16'h0800, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0); // out of range
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0000, 1);
        row(0, 1, 16'h07FE, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0); // last word
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h7E57, 0);
        row(0, 1, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0); // word 0 not aliased
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 1, 1, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h0BEE, 0); // flush+consume
        row(0, 1, 16'h0020, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0); // flush blocks accept
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0);
        row(0, 1, 16'h0020, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0); // load races RESP sample
        row(0, 0, 16'h0000, 0, 0, 1, 16'h0020, 16'hBEEF, 0, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'h1234, 0); // old data
        row(0, 1, 16'h0020, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'hBEEF, 0); // new data
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0);
        row(0, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0); // flush in BUSY
        row(0, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0);
        row(0, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0); // rst in BUSY
        row(1, 0, 16'h0000, 0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0000, 0);
        row(0, 1, 16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0);
        row(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 0, 1, 1, 16'hA5C3, 0); // memory kept
        row(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0000, 0);

        // Hold reset across one edge, then walk the table one row per cycle.
        rst = 1'b1;
        next_cycle();
        foreach (vecs[i]) begin
            rst = vecs[i].rst; req_valid = vecs[i].rv; req_addr = vecs[i].ra;
            resp_ready = vecs[i].rr; flush = vecs[i].fl; load_en = vecs[i].le;
            load_addr = vecs[i].la; load_data = vecs[i].ld;
            @(negedge clk);
            check($sformatf("row%0d.req_ready", i), 16'(rdy2), 16'(vecs[i].e_rdy));
            check($sformatf("row%0d.resp_valid", i), 16'(vld2), 16'(vecs[i].e_vld));
            if (vecs[i].chk) begin
                check($sformatf("row%0d.resp_data", i), dat2, vecs[i].e_data);
                check($sformatf("row%0d.resp_err", i), 16'(err2), 16'(vecs[i].e_err));
            end
            next_cycle();
        end

        // LATENCY=4: a flush in cycle 1 must kill the read for good.
        drive(1, 0, 16'h0000, 0, 0);
        next_cycle();
        drive(0, 1, 16'h0010, 0, 0);
        @(negedge clk);
        check("l4.accept_ready", 16'(rdy4), 16'h1);
        next_cycle();
        drive(0, 0, 16'h0000, 0, 1);
        @(negedge clk);
        check("l4.flush_ready", 16'(rdy4), 16'h0);
        next_cycle();
        drive(0, 0, 16'h0000, 1, 0);
        @(negedge clk);
        check("l4.ready_after_flush", 16'(rdy4), 16'h1);
        saw_vld = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (vld4) saw_vld = 1'b1;
        end
        check("l4.no_resp_after_flush", 16'(saw_vld), 16'h0);

        // LATENCY=4: the next request completes exactly four cycles after acceptance.
        next_cycle();
        drive(0, 1, 16'h0020, 0, 0);
        next_cycle();
        drive(0, 0, 16'h0000, 0, 0);
        lat_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (vld4 && lat_seen == 0) lat_seen = k;
            next_cycle();
        end
        check("l4.latency", 16'(lat_seen), 16'd4);
        check("l4.resp_data", dat4, 16'hBEEF);
        check("l4.resp_err", 16'(err4), 16'h0);

        // LATENCY=1: the response is visible the cycle after acceptance.
        drive(1, 0, 16'h0000, 0, 0);
        next_cycle();
        drive(0, 1, 16'h0010, 0, 0);
        @(negedge clk);
        check("l1.accept_ready", 16'(rdy1), 16'h1);
        next_cycle();
        drive(0, 0, 16'h0000, 1, 0);
        @(negedge clk);
        check("l1.resp_valid", 16'(vld1), 16'h1);
        check("l1.resp_data", dat1, 16'hA5C3);
        check("l1.ready_in_resp", 16'(rdy1), 16'h0);
        next_cycle();
        drive(0, 0, 16'h0000, 0, 0);
        @(negedge clk);
        check("l1.idle_valid", 16'(vld1), 16'h0);
        check("l1.idle_ready", 16'(rdy1), 16'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
